// File: rtl/cpu_core_mc_pkg.sv
// Shared types and constants for the multi-cycle CPU core.
package cpu_core_mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPER,
    S_MEM,
    S_EXEC,
    S_HALT
  } state_e;

  // Instruction class field [7:6]
  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_LOAD  = 2'b01;
  localparam logic [1:0] CLS_STORE = 2'b10;
  localparam logic [1:0] CLS_JUMP  = 2'b11;

  // ALU operation codes carried in the f field; f=0 in class 00 is HALT
  typedef enum logic [2:0] {
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_MOV = 3'd6,
    ALU_CMP = 3'd7
  } alu_op_e;

  // Jump condition codes carried in the f field of class 11
  localparam logic [2:0] JC_ALWAYS = 3'd0;
  localparam logic [2:0] JC_Z      = 3'd1;
  localparam logic [2:0] JC_NZ     = 3'd2;
  localparam logic [2:0] JC_C      = 3'd3;
  localparam logic [2:0] JC_NC     = 3'd4;

  // True when the instruction byte cannot be executed by a core with nregs registers
  function automatic logic instr_illegal(input logic [7:0] ir, input int nregs);
    logic bad;
    bad = (int'(ir[2:0]) >= nregs);
    case (ir[7:6])
      CLS_ALU:             if (ir[5:3] == 3'd0 && ir[2:0] != 3'd0) bad = 1'b1;
      CLS_LOAD, CLS_STORE: if (ir[5:3] != 3'd0) bad = 1'b1;
      default:             if (ir[5:3] > JC_NC) bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/cpu_core_mc_if.sv
// Memory port shared by instruction fetch, operand fetch and data access.
interface cpu_core_mc_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/cpu_core_mc_alu.sv
// Combinational ALU: result plus zero and carry/borrow flags.
module alu_param
  import cpu_core_mc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Select the result; the extra top bit of sum/diff is the carry or borrow
  always_comb begin
    result = '0;
    c      = 1'b0;
    case (alu_op_e'(op))
      ALU_ADD: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      ALU_SUB, ALU_CMP: begin
        result = diff[DATA_W-1:0];
        c      = diff[DATA_W];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_MOV: begin
        result = b;
        c      = c_in;
      end
      default: ;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: fetch, decode, operand, memory and execute sequencer.
module cpu_core_mc
  import cpu_core_mc_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 8,
  parameter int              NREGS    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  cpu_core_mc_if.master     mem,
  output logic              halted,
  output logic              err,
  output logic [ADDR_W-1:0] pc_o,
  output logic              flag_z,
  output logic              flag_c
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        ir_q;
  logic [ADDR_W-1:0] ar_q;
  logic [DATA_W-1:0] regs [NREGS];
  logic              err_q;
  logic              hold_q;
  logic              flag_z_q, flag_c_q;

  logic              req, we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              xfer;
  logic              take;

  logic [1:0]        cls;
  logic [2:0]        fld;
  logic [RIDX_W-1:0] ridx;
  logic              illegal;
  logic [DATA_W-1:0] rop;

  logic [DATA_W-1:0] alu_result;
  logic              alu_z, alu_c;

  assign cls     = ir_q[7:6];
  assign fld     = ir_q[5:3];
  assign ridx    = ir_q[RIDX_W-1:0];
  assign illegal = instr_illegal(ir_q, NREGS);
  assign rop     = regs[ridx];
  assign xfer    = req && mem.mem_ready;

  alu_param #(.DATA_W(DATA_W)) u_alu (
    .op     (fld),
    .a      (regs[0]),
    .b      (rop),
    .c_in   (flag_c_q),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state: memory states advance only on a completed access
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (xfer) state_d = S_DECODE;
      S_DECODE: begin
        if (illegal || (cls == CLS_ALU && fld == 3'd0)) state_d = S_HALT;
        else if (cls == CLS_ALU)                         state_d = S_EXEC;
        else                                             state_d = S_OPER;
      end
      S_OPER:   if (xfer) state_d = (cls == CLS_JUMP) ? S_EXEC : S_MEM;
      S_MEM:    if (xfer) state_d = S_FETCH;
      S_EXEC:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs; a stalled fetch keeps requesting even if en drops, and reset kills the request at once
  always_comb begin
    req   = 1'b0;
    we    = 1'b0;
    addr  = pc_q;
    wdata = rop;
    case (state_q)
      S_FETCH: req = en || hold_q;
      S_OPER:  req = 1'b1;
      S_MEM: begin
        req  = 1'b1;
        addr = ar_q;
        we   = (cls == CLS_STORE);
      end
      default: ;
    endcase
    if (rst) req = 1'b0;
  end

  // Jump condition evaluated against the current flags
  always_comb begin
    take = 1'b0;
    case (fld)
      JC_ALWAYS: take = 1'b1;
      JC_Z:      take = flag_z_q;
      JC_NZ:     take = !flag_z_q;
      JC_C:      take = flag_c_q;
      JC_NC:     take = !flag_c_q;
      default:   take = 1'b0;
    endcase
  end

  // PC, instruction/address registers, flags and error latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      ar_q     <= '0;
      err_q    <= 1'b0;
      hold_q   <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      hold_q <= (state_q == S_FETCH) && req && !mem.mem_ready;
      case (state_q)
        S_FETCH: if (xfer) begin
          ir_q <= mem.mem_rdata[7:0];
          pc_q <= pc_q + 1'b1;
        end
        S_DECODE: if (illegal) err_q <= 1'b1;
        S_OPER: if (xfer) begin
          ar_q <= mem.mem_rdata[ADDR_W-1:0];
          pc_q <= pc_q + 1'b1;
        end
        S_EXEC: begin
          if (cls == CLS_ALU) begin
            flag_z_q <= alu_z;
            flag_c_q <= alu_c;
          end else if (take) begin
            pc_q <= ar_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file: ALU writes the accumulator, LOAD writes the addressed register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state_q == S_EXEC && cls == CLS_ALU && fld != ALU_CMP) begin
      regs[0] <= alu_result;
    end else if (state_q == S_MEM && xfer && cls == CLS_LOAD) begin
      regs[ridx] <= mem.mem_rdata;
    end
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;

  assign halted = (state_q == S_HALT);
  assign err    = err_q;
  assign pc_o   = pc_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc with a write scoreboard and a request-stability monitor.
module tb_cpu_core_mc;
  import cpu_core_mc_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int NREGS  = 4;
  localparam logic [7:0] RESET_PC = 8'h00;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       en    = 1'b1;
  logic       ready = 1'b1;
  logic       halted, err, flag_z, flag_c;
  logic [7:0] pc_o;
  logic [7:0] mem [256];

  int   checks      = 0;
  int   errors      = 0;
  int   write_count = 0;
  int   ready_mode  = 0;
  int   cycles      = 0;
  logic saw_req     = 1'b0;
  logic stall_prev  = 1'b0;
  logic [16:0] held_prev = '0;
  wr_t  got_w;
  wr_t  exp_q [$];

  cpu_core_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  assign bus.mem_ready = ready;
  assign bus.mem_rdata = mem[bus.mem_addr];

  cpu_core_mc #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NREGS    (NREGS),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mem    (bus),
    .halted (halted),
    .err    (err),
    .pc_o   (pc_o),
    .flag_z (flag_z),
    .flag_c (flag_c)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic start_test();
    rst        = 1'b1;
    ready_mode = 0;
    en         = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    exp_q.delete();
    write_count = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic run_until_halt(input int limit);
    cycles = 0;
    while (!halted && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_output("halt_reached", halted, 1);
  endtask

  task automatic check_end(input string tag, input int exp_cycles, input logic [7:0] exp_pc,
                           input logic exp_z, input logic exp_c);
    check_output({tag, "_cycles"}, cycles, exp_cycles);
    check_output({tag, "_pc"}, pc_o, exp_pc);
    check_output({tag, "_err"}, err, 0);
    check_output({tag, "_z"}, flag_z, exp_z);
    check_output({tag, "_c"}, flag_c, exp_c);
    check_output({tag, "_writes_done"}, exp_q.size(), 0);
  endtask

  // Ready driver: always ready, random ready, or stalled
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(0, 3) == 0);
        default: ready = 1'b0;
      endcase
    end
  end

  // Monitor between edges: held request fields while stalled, and scoreboarded writes
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_output("req_held", bus.mem_req, 1);
          check_output("req_fields_held", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, held_prev);
        end
        if (bus.mem_req && bus.mem_we && ready) begin
          write_count++;
          check_output("write_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            got_w = exp_q.pop_front();
            check_output("write_addr_data", {bus.mem_addr, bus.mem_wdata}, got_w);
          end
        end
        stall_prev = bus.mem_req && !ready;
        held_prev  = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    #3;
    check_output("rst_req", bus.mem_req, 0);
    check_output("rst_we", bus.mem_we, 0);
    check_output("rst_pc", pc_o, RESET_PC);
    check_output("rst_halted", halted, 0);
    check_output("rst_err", err, 0);
    check_output("rst_flags", {flag_z, flag_c}, 2'b00);

    // LOAD r1 from 0x10, ADD r1, STORE r0
    start_test();
    mem[0] = 8'h41; mem[1] = 8'h10; mem[8'h10] = 8'h05;
    mem[2] = 8'h09;
    mem[3] = 8'h80; mem[4] = 8'h20;
    mem[5] = 8'h00;
    expect_write(8'h20, 8'h05);
    release_reset();
    run_until_halt(100);
    check_end("add", 13, 8'h06, 1'b0, 1'b0);

    // 0xFF + 0x01 wraps to zero with carry
    start_test();
    mem[0] = 8'h40; mem[1] = 8'h30; mem[8'h30] = 8'hFF;
    mem[2] = 8'h41; mem[3] = 8'h31; mem[8'h31] = 8'h01;
    mem[4] = 8'h09;
    mem[5] = 8'h80; mem[6] = 8'h40;
    mem[7] = 8'h00;
    expect_write(8'h40, 8'h00);
    release_reset();
    run_until_halt(100);
    check_end("add_wrap", 17, 8'h08, 1'b1, 1'b1);

    // 0 - 1 borrows; MOV keeps C; CMP sets flags without writing r0
    start_test();
    mem[0]  = 8'h41; mem[1] = 8'h31; mem[8'h31] = 8'h01;
    mem[2]  = 8'h11;
    mem[3]  = 8'h80; mem[4]  = 8'h41;
    mem[5]  = 8'h31;
    mem[6]  = 8'h80; mem[7]  = 8'h42;
    mem[8]  = 8'h39;
    mem[9]  = 8'h80; mem[10] = 8'h43;
    mem[11] = 8'h00;
    expect_write(8'h41, 8'hFF);
    expect_write(8'h42, 8'h01);
    expect_write(8'h43, 8'h01);
    release_reset();
    run_until_halt(100);
    check_end("sub_mov_cmp", 27, 8'h0C, 1'b1, 1'b0);

    // AND gives zero, JUMP Z taken to 0x20
    start_test();
    mem[0] = 8'h18;
    mem[1] = 8'hC8; mem[2] = 8'h20;
    mem[3] = 8'h00; mem[8'h20] = 8'h00;
    release_reset();
    run_until_halt(100);
    check_end("jz_taken", 9, 8'h21, 1'b1, 1'b0);

    // OR gives nonzero, JUMP Z falls through past the operand
    start_test();
    mem[0] = 8'h41; mem[1] = 8'h30; mem[8'h30] = 8'h01;
    mem[2] = 8'h21;
    mem[3] = 8'hC8; mem[4] = 8'h20;
    mem[5] = 8'h00; mem[8'h20] = 8'h00;
    release_reset();
    run_until_halt(100);
    check_end("jz_not_taken", 13, 8'h06, 1'b0, 1'b0);

    // STORE with random wait states: one write, fields held while stalled
    start_test();
    ready_mode = 1;
    mem[0] = 8'h41; mem[1] = 8'h30; mem[8'h30] = 8'hA5;
    mem[2] = 8'h81; mem[3] = 8'h50;
    mem[4] = 8'h00;
    expect_write(8'h50, 8'hA5);
    release_reset();
    run_until_halt(400);
    check_output("rand_pc", pc_o, 8'h05);
    check_output("rand_write_count", write_count, 1);
    check_output("rand_writes_done", exp_q.size(), 0);

    // Illegal LOAD r7 halts with err and never requests again
    start_test();
    mem[0] = 8'h47;
    release_reset();
    run_until_halt(50);
    check_output("illegal_cycles", cycles, 2);
    check_output("illegal_err", err, 1);
    check_output("illegal_pc", pc_o, 8'h01);
    saw_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      saw_req = saw_req | bus.mem_req;
    end
    check_output("illegal_req_quiet", saw_req, 0);
    check_output("illegal_still_halted", halted, 1);

    // en low keeps the core idle; HALT byte stops cleanly
    start_test();
    en = 1'b0;
    release_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_output("idle_req", bus.mem_req, 0);
    check_output("idle_pc", pc_o, 8'h00);
    en = 1'b1;
    run_until_halt(50);
    check_output("halt_cycles", cycles, 2);
    check_output("halt_err", err, 0);
    check_output("halt_pc", pc_o, 8'h01);

    // Reset while the data access is stalled
    start_test();
    mem[0] = 8'h41; mem[1] = 8'h30; mem[8'h30] = 8'h5A;
    release_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ready_mode = 2;
    check_output("mem_state_addr", bus.mem_addr, 8'h30);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_output("stall_req", bus.mem_req, 1);
    check_output("stall_pc", pc_o, 8'h02);
    rst = 1'b1;
    #1;
    check_output("midrst_req", bus.mem_req, 0);
    check_output("midrst_pc", pc_o, RESET_PC);
    check_output("midrst_halted", halted, 0);
    ready_mode = 0;

    // PC wraps after fetching at 0xFF
    start_test();
    mem[0] = 8'hC0; mem[1] = 8'hFF;
    mem[8'hFF] = 8'h00;
    release_reset();
    run_until_halt(50);
    check_end("pc_wrap", 6, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
